// File: rtl/mdio_mgmt_master.sv
// MDIO/MDC management master (Clause 22 frames, optional Clause 45).
// Runs entirely in the sysck domain; MDC is a register toggled by a divider tick.
// Optional feature macro: MDIO_CLAUSE45_EN adds cmd_c45 and Clause 45 framing.
module mdio_mgmt_master #(
    parameter int CLK_DIV = 50,
    parameter int PRE_LEN = 32,
    parameter int CNT_W   = 10
) (
    input  logic        sysck,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_CLAUSE45_EN
    input  logic        cmd_c45,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdo,
    output logic        mdo_en,
    input  logic        mdi
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_GAP, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              mdc_q, mdc_d;
    logic              mdo_q, mdo_d;
    logic              mdo_en_q, mdo_en_d;
    logic [31:0]       out_sh_q, out_sh_d;   // {ST, OP, PHYAD, REGAD, TA, DATA}
    logic [15:0]       in_sh_q, in_sh_d;
    logic              rd_q, rd_d;
    logic              ta_err_q, ta_err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;

    logic              c45;
    logic              cmd_legal;
    logic              cmd_rd;
    logic [1:0]        cmd_st;
    logic              tick;
    logic              emit;

`ifdef MDIO_CLAUSE45_EN
    assign c45 = cmd_c45;
`else
    assign c45 = 1'b0;
`endif

    // Clause 45 accepts every op; ops 1x are read-type there.
    assign cmd_legal = c45 | (cmd_op == 2'b01) | (cmd_op == 2'b10);
    assign cmd_rd    = c45 ? cmd_op[1] : (cmd_op == 2'b10);
    assign cmd_st    = c45 ? 2'b00 : 2'b01;

    assign busy      = (state_q != S_IDLE) && (state_q != S_RESP);
    assign cmd_ready = (state_q == S_IDLE);
    assign tick      = (cnt_q == CNT_W'(CLK_DIV - 1));

    assign mdc       = mdc_q;
    assign mdo       = mdo_q;
    assign mdo_en    = mdo_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state, divider, serializer and capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bit_cnt_d   = bit_cnt_q;
        mdc_d       = mdc_q;
        mdo_d       = mdo_q;
        mdo_en_d    = mdo_en_q;
        out_sh_d    = out_sh_q;
        in_sh_d     = in_sh_q;
        rd_d        = rd_q;
        ta_err_d    = ta_err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        emit        = 1'b0;

        if (busy) cnt_d = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_d      = cmd_rd;
                    ta_err_d  = 1'b0;
                    bit_cnt_d = '0;
                    out_sh_d  = {cmd_st, cmd_op, cmd_phyad, cmd_regad, 2'b10, cmd_wdata};
                    if (!cmd_legal) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = (PRE_LEN == 0) ? S_HDR : S_PRE;
                        emit    = 1'b1;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: begin
                if (tick) begin
                    if (!mdc_q) begin
                        // Rising edge: sample MDIO for read-type frames.
                        mdc_d = 1'b1;
                        if (rd_q && state_q == S_TA && bit_cnt_q == 6'd1) ta_err_d = mdi;
                        if (rd_q && state_q == S_DATA) in_sh_d = {in_sh_q[14:0], mdi};
                    end else begin
                        // Falling edge: advance to the next bit cell.
                        mdc_d     = 1'b0;
                        emit      = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        case (state_q)
                            S_PRE:  if (bit_cnt_q == 6'(PRE_LEN - 1)) begin
                                        state_d = S_HDR; bit_cnt_d = '0;
                                    end
                            S_HDR:  if (bit_cnt_q == 6'd13) begin
                                        state_d = S_TA; bit_cnt_d = '0;
                                    end
                            S_TA:   if (bit_cnt_q == 6'd1) begin
                                        state_d = S_DATA; bit_cnt_d = '0;
                                    end
                            S_DATA: if (bit_cnt_q == 6'd15) begin
                                        state_d = S_GAP; bit_cnt_d = '0;
                                    end
                            default: begin
                                state_d     = S_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = ta_err_q;
                                if (rd_q) rsp_rdata_d = in_sh_q;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Drive the bit belonging to the state being entered/continued.
        if (emit) begin
            case (state_d)
                S_PRE: begin
                    mdo_d    = 1'b1;
                    mdo_en_d = 1'b1;
                end
                S_HDR: begin
                    mdo_d    = out_sh_d[31];
                    mdo_en_d = 1'b1;
                    out_sh_d = {out_sh_d[30:0], 1'b0};
                end
                S_TA, S_DATA: begin
                    mdo_d    = rd_d ? 1'b1 : out_sh_d[31];
                    mdo_en_d = !rd_d;
                    out_sh_d = {out_sh_d[30:0], 1'b0};
                end
                default: begin
                    mdo_d    = 1'b1;
                    mdo_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge sysck or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            mdc_q       <= 1'b0;
            mdo_q       <= 1'b1;
            mdo_en_q    <= 1'b0;
            out_sh_q    <= '0;
            in_sh_q     <= '0;
            rd_q        <= 1'b0;
            ta_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            mdc_q       <= mdc_d;
            mdo_q       <= mdo_d;
            mdo_en_q    <= mdo_en_d;
            out_sh_q    <= out_sh_d;
            in_sh_q     <= in_sh_d;
            rd_q        <= rd_d;
            ta_err_q    <= ta_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mdio_mgmt_master.sv
// Scoreboard bench for mdio_mgmt_master with a bit-level PHY model.
module tb_mdio_mgmt_master;
    localparam int CLK_DIV = 2;
    localparam int PRE_LEN = 32;
    localparam int NB      = PRE_LEN + 33;
    localparam int LAT     = 2 * CLK_DIV * NB + 1;

    logic        sysck = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_phyad = '0, cmd_regad = '0;
    logic [15:0] cmd_wdata = '0;
`ifdef MDIO_CLAUSE45_EN
    logic        cmd_c45 = 1'b0;
`endif
    logic        rsp_valid, rsp_err, busy, mdc, mdo, mdo_en;
    logic [15:0] rsp_rdata;
    logic        mdi = 1'b1;

    mdio_mgmt_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN), .CNT_W(10)) dut (
        .sysck(sysck), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
`ifdef MDIO_CLAUSE45_EN
        .cmd_c45(cmd_c45),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mdc(mdc), .mdo(mdo), .mdo_en(mdo_en), .mdi(mdi)
    );

    always #5 sysck = ~sysck;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0]   rdata;
        logic          err;
        int            lat;
        int            nbits;
        logic [NB-1:0] mdo, en, care;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_rdata = '0;

    // Reference frame: one entry per MDC rising edge, in time order.
    function automatic exp_t mk(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                                input logic [15:0] wd, input logic c45, input logic ok,
                                input logic [15:0] pd);
        exp_t        e;
        logic        legal, rd;
        logic [13:0] hdr;
        legal = c45 || op == 2'b01 || op == 2'b10;
        rd    = c45 ? op[1] : (op == 2'b10);
        hdr   = {(c45 ? 2'b00 : 2'b01), op, pa, ra};
        e.mdo = '0; e.en = '0; e.care = '0;
        if (!legal) begin
            e.err = 1'b1; e.rdata = model_rdata; e.lat = 1; e.nbits = 0;
            return e;
        end
        for (int i = 0; i < NB; i++) begin
            if (i < PRE_LEN) begin
                e.mdo[i] = 1'b1; e.en[i] = 1'b1; e.care[i] = 1'b1;
            end else if (i < PRE_LEN + 14) begin
                e.mdo[i] = hdr[13 - (i - PRE_LEN)]; e.en[i] = 1'b1; e.care[i] = 1'b1;
            end else if (i < PRE_LEN + 16) begin
                e.mdo[i] = (i == PRE_LEN + 14); e.en[i] = !rd; e.care[i] = !rd;
            end else if (i < PRE_LEN + 32) begin
                e.mdo[i] = wd[15 - (i - PRE_LEN - 16)]; e.en[i] = !rd; e.care[i] = !rd;
            end else begin
                e.mdo[i] = 1'b1; e.en[i] = 1'b0; e.care[i] = 1'b1;
            end
        end
        if (rd) model_rdata = ok ? pd : 16'hFFFF;
        e.err   = rd && !ok;
        e.rdata = model_rdata;
        e.lat   = LAT;
        e.nbits = NB;
        return e;
    endfunction

    // PHY model: after MDC rise r, present the bit for period r+1.
    logic        phy_ok = 1'b0;
    logic [15:0] phy_data = '0;
    int          rises = 0;
    logic        phy_prev = 1'b0;
    always @(negedge sysck) begin
        if (!reset || !busy) begin
            rises = 0;
            mdi   = 1'b1;
        end else if (mdc && !phy_prev) begin
            rises++;
            mdi = 1'b1;
            if (phy_ok) begin
                if (rises == PRE_LEN + 15) mdi = 1'b0;
                else if (rises >= PRE_LEN + 16 && rises < PRE_LEN + 32)
                    mdi = phy_data[15 - (rises - PRE_LEN - 16)];
            end
        end
        phy_prev = mdc;
    end

    // Monitor: capture MDIO at each MDC rise, check responses against the scoreboard.
    int            cyc = 0, acc_cyc = 0, rsp_cyc = -100, ready_viol = 0;
    logic          mon_prev = 1'b0;
    logic          cap_mdo[$], cap_en[$];
    exp_t          me;
    logic [NB-1:0] gm, ge;
    always @(negedge sysck) begin
        cyc++;
        if (!reset) begin
            cap_mdo.delete(); cap_en.delete(); mon_prev = 1'b0;
        end else begin
            if (mdc && !mon_prev) begin
                cap_mdo.push_back(mdo); cap_en.push_back(mdo_en);
            end
            mon_prev = mdc;
            if (busy && cmd_ready) ready_viol++;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none");
                end else begin
                    me = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, me.rdata);
                    chk("rsp_err", rsp_err, me.err);
                    chk("latency", cyc - acc_cyc, me.lat);
                    chk("mdc_rises", cap_mdo.size(), me.nbits);
                    if (me.nbits > 0) begin
                        for (int i = 0; i < NB; i++) begin
                            gm[i] = (i < cap_mdo.size()) ? cap_mdo[i] : 1'bx;
                            ge[i] = (i < cap_en.size()) ? cap_en[i] : 1'bx;
                        end
                        chk("mdo_stream", gm & me.care, me.mdo & me.care);
                        chk("mdo_en_stream", ge, me.en);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc; cap_mdo.delete(); cap_en.delete();
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic c45, input logic ok,
                         input logic [15:0] pd);
        int k = 0;
        sb.push_back(mk(op, pa, ra, wd, c45, ok, pd));
        phy_ok = ok; phy_data = pd;
        cmd_op = op; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
`ifdef MDIO_CLAUSE45_EN
        cmd_c45 = c45;
`endif
        cmd_valid = 1'b1;
        do begin
            @(negedge sysck); k++;
        end while (!cmd_ready && k < 2 * LAT);
        if (!cmd_ready) chk("accept_timeout", 1, 0);
        @(posedge sysck); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < LAT + 20) begin
            @(negedge sysck); k++;
        end
        if (!rsp_valid) chk("rsp_timeout", 1, 0);
        @(posedge sysck); #1;
    endtask

    initial begin
        logic [1:0] rop;
        logic       rc45;
        #2 reset = 1'b0;
        repeat (3) @(posedge sysck);
        #1;
        chk("rst_mdc", mdc, 0);
        chk("rst_mdo", mdo, 1);
        chk("rst_mdo_en", mdo_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        reset = 1'b1;
        @(posedge sysck); #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        issue(2'b01, 5'h01, 5'h04, 16'h01E1, 1'b0, 1'b0, 16'h0000); wait_rsp();
        issue(2'b10, 5'h1F, 5'h02, 16'h0000, 1'b0, 1'b1, 16'h796D); wait_rsp();
        issue(2'b10, 5'h03, 5'h05, 16'h0000, 1'b0, 1'b0, 16'h0000); wait_rsp();
        issue(2'b00, 5'h03, 5'h05, 16'h1234, 1'b0, 1'b0, 16'h0000); wait_rsp();
        issue(2'b11, 5'h07, 5'h09, 16'h4321, 1'b0, 1'b0, 16'h0000); wait_rsp();
        issue(2'b10, 5'h11, 5'h0A, 16'h0000, 1'b0, 1'b1, 16'hA5C3); wait_rsp();
        issue(2'b01, 5'h02, 5'h00, 16'hBEEF, 1'b0, 1'b0, 16'h0000); wait_rsp();

        // Back-to-back writes with cmd_valid held high.
        issue(2'b01, 5'h04, 5'h10, 16'h8001, 1'b0, 1'b0, 16'h0000);
        issue(2'b01, 5'h05, 5'h11, 16'h7FFE, 1'b0, 1'b0, 16'h0000);
        chk("b2b_accept_cycle", acc_cyc, rsp_cyc + 1);
        wait_rsp();

`ifdef MDIO_CLAUSE45_EN
        issue(2'b00, 5'h05, 5'h01, 16'h0010, 1'b1, 1'b0, 16'h0000); wait_rsp();
        issue(2'b11, 5'h05, 5'h01, 16'h0000, 1'b1, 1'b1, 16'h3C5A); wait_rsp();
`endif

        for (int t = 0; t < 12; t++) begin
            rop  = 2'($urandom_range(0, 3));
`ifdef MDIO_CLAUSE45_EN
            rc45 = 1'($urandom_range(0, 1));
`else
            rc45 = 1'b0;
`endif
            issue(rop, 5'($urandom), 5'($urandom), 16'($urandom), rc45,
                  ($urandom_range(0, 3) != 0), 16'($urandom));
            wait_rsp();
        end

        // Reset during header bit 5 of a write: frame abandoned, no response.
        issue(2'b01, 5'h0C, 5'h0D, 16'h5555, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < LAT && cap_mdo.size() < PRE_LEN + 6; k++) @(posedge sysck);
        chk("reached_hdr5", cap_mdo.size(), PRE_LEN + 6);
        #2 reset = 1'b0;
        void'(sb.pop_back());
        model_rdata = '0;
        #1;
        chk("mid_rst_mdc", mdc, 0);
        chk("mid_rst_mdo_en", mdo_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mdo", mdo, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 0);
        repeat (3) @(posedge sysck);
        #1 reset = 1'b1;
        @(posedge sysck); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        repeat (LAT) @(posedge sysck);
        #1;
        issue(2'b01, 5'h0C, 5'h0D, 16'h5555, 1'b0, 1'b0, 16'h0000); wait_rsp();
        issue(2'b10, 5'h0C, 5'h0D, 16'h0000, 1'b0, 1'b1, 16'hC0DE); wait_rsp();

        repeat (5) @(posedge sysck);
        chk("ready_while_busy", ready_viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
